jk_bank_arbiter: RTL and testbench

JK_BANK_ARBITER -- requirements
Module: jk_bank_arbiter

---
 rtl/jk_bank_arbiter.sv | 137 +++++++++++++
 tb/tb_jk_bank_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter giving NREQ requesters access to a shared bank of JK cells,
// with optional multi-cycle ownership (lock) bounded by a MAXLOCK watchdog.
module jk_bank_arbiter #(
  parameter int NREQ    = 4,
  parameter int NBITS   = 8,
  parameter int MAXLOCK = 8,
  localparam int IW     = $clog2(NBITS),
  localparam int RW     = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    lock,
  input  logic [NREQ-1:0]    j,
  input  logic [NREQ-1:0]    k,
  input  logic [NREQ*IW-1:0] idx,
  output logic [NREQ-1:0]    gnt,
  output logic [NBITS-1:0]   q,
  output logic [RW-1:0]      owner,
  output logic               locked,
  output logic               err
);

  localparam int CW = $clog2(MAXLOCK + 1);
  // An out-of-range index can only be encoded when NBITS is not a power of two.
  localparam bit CAN_OOR = ((1 << IW) != NBITS);

  typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [RW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [RW-1:0]     owner_q, owner_d;
  logic [CW-1:0]     lock_cnt_q, lock_cnt_d;
  logic [NBITS-1:0]  q_q, q_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              err_q, err_d;

  logic              exec;
  logic              found;
  logic [RW-1:0]     sel;
  logic [RW-1:0]     cand;
  logic [IW-1:0]     idx_w;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    q_d        = q_q;
    gnt_d      = '0;
    err_d      = 1'b0;
    exec       = 1'b0;
    found      = 1'b0;
    sel        = '0;
    cand       = '0;
    idx_w      = '0;

    case (state_q)
      ST_IDLE: begin
        for (int o = 0; o < NREQ; o++) begin
          cand = RW'((int'(rr_ptr_q) + o) % NREQ);
          if (!found && req[cand]) begin
            found = 1'b1;
            sel   = cand;
          end
        end
        if (found) begin
          exec     = 1'b1;
          rr_ptr_d = (int'(sel) == NREQ - 1) ? '0 : sel + 1'b1;
          if (lock[sel]) begin
            state_d    = ST_LOCKED;
            owner_d    = sel;
            lock_cnt_d = CW'(1);
          end
        end
      end
      ST_LOCKED: begin
        sel        = owner_q;
        exec       = req[owner_q];
        lock_cnt_d = lock_cnt_q + 1'b1;
        // Watchdog release forces IDLE even when the owner still asks to lock.
        if (!lock[owner_q] || (lock_cnt_q >= CW'(MAXLOCK - 1))) begin
          state_d    = ST_IDLE;
          lock_cnt_d = '0;
          rr_ptr_d   = (int'(owner_q) == NREQ - 1) ? '0 : owner_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (exec) begin
      gnt_d = NREQ'(1) << sel;
      idx_w = idx[int'(sel)*IW +: IW];
      if (CAN_OOR && ({{(32-IW){1'b0}}, idx_w} >= NBITS)) begin
        err_d = 1'b1;
      end else begin
        for (int b = 0; b < NBITS; b++) begin
          if (IW'(b) == idx_w) begin
            case ({j[sel], k[sel]})
              2'b10:   q_d[b] = 1'b1;
              2'b01:   q_d[b] = 1'b0;
              2'b11:   q_d[b] = ~q_q[b];
              default: q_d[b] = q_q[b];
            endcase
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      lock_cnt_q <= '0;
      q_q        <= '0;
      gnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
      q_q        <= q_d;
      gnt_q      <= gnt_d;
      err_q      <= err_d;
    end
  end

  assign gnt    = gnt_q;
  assign q      = q_q;
  assign owner  = owner_q;
  assign locked = (state_q == ST_LOCKED);
  assign err    = err_q;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed and random checks of jk_bank_arbiter against a behavioural model.
// A second instance with a 5-cell bank exercises out-of-range indices.
module tb_jk_bank_arbiter;

  localparam int NREQ    = 4;
  localparam int MAXLOCK = 8;

  logic        clk;
  logic        reset;
  logic [3:0]  req, lock, j, k;
  logic [11:0] idx;
  logic [3:0]  gnt, gnt_e;
  logic [7:0]  q;
  logic [4:0]  q_e;
  logic [1:0]  owner, owner_e;
  logic        locked, locked_e, err, err_e;

  int n_cmp = 0;
  int n_err = 0;

  jk_bank_arbiter #(.NREQ(4), .NBITS(8), .MAXLOCK(MAXLOCK)) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .j(j), .k(k), .idx(idx),
    .gnt(gnt), .q(q), .owner(owner), .locked(locked), .err(err)
  );

  jk_bank_arbiter #(.NREQ(4), .NBITS(5), .MAXLOCK(MAXLOCK)) dut_e (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .j(j), .k(k), .idx(idx),
    .gnt(gnt_e), .q(q_e), .owner(owner_e), .locked(locked_e), .err(err_e)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: arbitration is shared, each bank modelled separately
  logic [7:0] m_q[2];
  bit         m_err[2];
  int         m_nb[2] = '{8, 5};
  bit         m_locked;
  int         m_owner, m_cnt, m_ptr;
  logic [3:0] m_gnt;

  function automatic logic [2:0] idx_of(int w);
    logic [3:0] base;
    base = 4'(w) * 4'd3;
    return idx[base +: 3];
  endfunction

  task automatic model_reset();
    m_q[0] = '0; m_q[1] = '0; m_err[0] = 0; m_err[1] = 0;
    m_locked = 0; m_owner = 0; m_cnt = 0; m_ptr = 0; m_gnt = '0;
  endtask

  task automatic model_apply(int w);
    logic [2:0] ix;
    bit         jb, kb;
    ix = idx_of(w);
    jb = j[2'(w)];
    kb = k[2'(w)];
    m_gnt[2'(w)] = 1'b1;
    for (int d = 0; d < 2; d++) begin
      if (int'(ix) >= m_nb[d]) m_err[d] = 1;
      else if (jb && kb) m_q[d][ix] = ~m_q[d][ix];
      else if (jb)       m_q[d][ix] = 1'b1;
      else if (kb)       m_q[d][ix] = 1'b0;
    end
  endtask

  task automatic model_step();
    int w;
    w = -1;
    m_gnt = '0; m_err[0] = 0; m_err[1] = 0;
    if (!m_locked) begin
      for (int o = 0; o < NREQ; o++) begin
        int c;
        c = (m_ptr + o) % NREQ;
        if (w < 0 && req[2'(c)]) w = c;
      end
      if (w >= 0) begin
        model_apply(w);
        m_ptr = (w + 1) % NREQ;
        if (lock[2'(w)]) begin
          m_locked = 1; m_owner = w; m_cnt = 1;
        end
      end
    end else begin
      if (req[2'(m_owner)]) model_apply(m_owner);
      m_cnt++;
      if (m_cnt == MAXLOCK) begin
        m_locked = 0;
        m_ptr = (m_owner + 1) % NREQ;
      end else if (!lock[2'(m_owner)]) begin
        m_locked = 0;
      end
    end
  endtask

  // scoreboard
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("gnt", 32'(gnt), 32'(m_gnt));
    chk("gnt_e", 32'(gnt_e), 32'(m_gnt));
    chk("q", 32'(q), 32'(m_q[0]));
    chk("q_e", 32'(q_e), 32'(m_q[1]));
    chk("err", 32'(err), 32'(m_err[0]));
    chk("err_e", 32'(err_e), 32'(m_err[1]));
    chk("locked", 32'(locked), 32'(m_locked));
    if (m_locked) chk("owner", 32'(owner), 32'(m_owner));
  endtask

  // driver: inputs change at negedge, model follows each active edge
  task automatic cycle();
    @(posedge clk);
    if (reset) model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(int r, logic [3:0] lk, logic jv, logic kv, logic [2:0] ix);
    req[2'(r)] = 1'b1; lock[2'(r)] = lk[0]; j[2'(r)] = jv; k[2'(r)] = kv;
    idx[4'(r)*4'd3 +: 3] = ix;
  endtask

  task automatic clear_inputs();
    req = '0; lock = '0; j = '0; k = '0; idx = '0;
  endtask

  int pulses;

  initial begin
    clear_inputs();
    reset = 1'b0;
    model_reset();
    #1 check_all();
    cycle();
    cycle();
    reset = 1'b1;

    // idle after reset
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk("idle_q", 32'(q), 32'h0);
      chk("idle_gnt", 32'(gnt), 32'h0);
    end

    // everyone requests a set of its own cell
    for (int r = 0; r < 4; r++) drive(r, 4'd0, 1'b1, 1'b0, 3'(r));
    for (int c = 0; c < 4; c++) begin
      cycle();
      chk("rr_gnt", 32'(gnt), 32'(4'b0001 << c));
    end
    chk("rr_q", 32'(q), 32'h0F);
    clear_inputs();

    // clear cell 0, then requester 2 locks and toggles cell 5 while 0 waits
    drive(0, 4'd0, 1'b0, 1'b1, 3'd0);
    cycle();
    chk("clr_q0", 32'(q[0]), 32'h0);
    clear_inputs();
    drive(2, 4'd1, 1'b1, 1'b1, 3'd5);
    cycle();
    chk("lk_q5_a", 32'(q[5]), 32'h1);
    drive(0, 4'd0, 1'b1, 1'b0, 3'd0);
    cycle();
    chk("lk_q5_b", 32'(q[5]), 32'h0);
    chk("lk_gnt_b", 32'(gnt), 32'b0100);
    cycle();
    chk("lk_q5_c", 32'(q[5]), 32'h1);
    chk("lk_locked", 32'(locked), 32'h1);
    req[2] = 1'b0; lock[2] = 1'b0;
    cycle();
    chk("lk_release", 32'(locked), 32'h0);
    cycle();
    chk("lk_wait_gnt", 32'(gnt), 32'b0001);
    chk("lk_wait_q0", 32'(q[0]), 32'h1);
    clear_inputs();
    cycle();

    // watchdog: requester 1 never drops lock while 2 waits
    drive(1, 4'd1, 1'b1, 1'b1, 3'd1);
    drive(2, 4'd0, 1'b1, 1'b0, 3'd7);
    pulses = 0;
    for (int c = 0; c < MAXLOCK; c++) begin
      cycle();
      if (gnt[1]) pulses++;
    end
    chk("wd_pulses", 32'(pulses), 32'(MAXLOCK));
    chk("wd_locked", 32'(locked), 32'h0);
    cycle();
    chk("wd_next_gnt", 32'(gnt), 32'b0100);
    clear_inputs();
    cycle();

    // index beyond the 5-cell bank
    drive(0, 4'd0, 1'b1, 1'b1, 3'd7);
    cycle();
    chk("oor_err_e", 32'(err_e), 32'h1);
    chk("oor_gnt_e", 32'(gnt_e), 32'b0001);
    clear_inputs();
    cycle();

    // reset in the middle of a lock
    drive(1, 4'd1, 1'b1, 1'b0, 3'd3);
    cycle();
    chk("mid_locked", 32'(locked), 32'h1);
    #2 reset = 1'b0;
    #1 model_reset();
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_locked", 32'(locked), 32'h0);
    check_all();
    @(negedge clk);
    clear_inputs();
    cycle();
    reset = 1'b1;
    drive(3, 4'd0, 1'b1, 1'b0, 3'd2);
    cycle();
    chk("post_rst_gnt", 32'(gnt), 32'b1000);
    clear_inputs();

    // random traffic, lock biased low so watchdog and releases both occur
    for (int c = 0; c < 400; c++) begin
      req  = 4'($urandom_range(0, 15));
      lock = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      j    = 4'($urandom_range(0, 15));
      k    = 4'($urandom_range(0, 15));
      idx  = 12'($urandom);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
